store_port_arbiter: RTL and testbench
=====================================

STORE_PORT_ARBITER -- requirements
Module: store_port_arbiter

Interface
REQ-001 The block SHALL have parameter NR_PORTS, default 2, number of store requesters sharing the D$ write port (legal range 2..4).
REQ-002 The block SHALL have parameter DATA_W, default 64, store data width; byte-enable width is DATA_W/8.
REQ-003 The block SHALL have the port clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have the port rst_ni  in  1  reset, synchronous and active-low.
REQ-005 The block SHALL have the port req_i  in  NR_PORTS  per-requester store request valid.
REQ-006 The block SHALL have the port req_payload_i  in  NR_PORTS x store_port_req_t  per-requester address, data, be, size.
REQ-007 The block SHALL have the port gnt_o  out  NR_PORTS  one-hot acceptance pulse to the winning requester.
REQ-008 The block SHALL have the port dcache_req_o  out  1  downstream write request valid.
REQ-009 The block SHALL have the port dcache_payload_o  out  store_port_req_t  held downstream payload.
REQ-010 The block SHALL have the port dcache_gnt_i  in  1  downstream acceptance.
REQ-011 The block SHALL have the port busy_o  out  1  high while a captured store awaits dcache_gnt_i.
REQ-012 The block SHALL have the port winner_id_o  out  clog2(NR_PORTS)  index of the requester whose store is held.

Function
REQ-013 The block SHALL implement FSM states IDLE (buffer empty) and HOLD (one store captured, dcache_req_o=1).
REQ-014 In IDLE with any req_i bit set, the block SHALL select one winner, pulse its gnt_o in the same cycle, capture its payload and id, and enter HOLD next cycle.
REQ-015 In HOLD, dcache_req_o and dcache_payload_o SHALL stay asserted and stable until the cycle dcache_gnt_i=1.
REQ-016 In HOLD with dcache_gnt_i=1 and any req_i set, the block SHALL accept a new winner in that same cycle and remain in HOLD (throughput one store per cycle).
REQ-017 In HOLD with dcache_gnt_i=1 and no req_i, the block SHALL return to IDLE.
REQ-018 In HOLD with dcache_gnt_i=0, gnt_o SHALL be all zero regardless of req_i.
REQ-019 At most one gnt_o bit SHALL be high per cycle, and only for a requester with req_i high.
REQ-020 Round-robin: the winner SHALL be the first requesting index strictly after the previous winner, wrapping NR_PORTS-1 to 0; pointer advances only on a gnt_o pulse.
REQ-021 dcache_gnt_i while in IDLE SHALL be ignored.
REQ-022 Requesters SHALL hold req_i and payload until gnt_o; the block does not require this but gives no guarantee of capture otherwise.

Reset
REQ-023 On rst_ni=0 at a clock edge, the block SHALL enter IDLE, clear the held payload to zero, and set the round-robin pointer to NR_PORTS-1 (port 0 wins first).
REQ-024 During and after reset, dcache_req_o=0, busy_o=0, gnt_o=0, winner_id_o=0; a held store is discarded if reset occurs mid-HOLD.

Configuration
REQ-025 With STORE_ARB_FIXED_PRIO_EN defined, port 0 SHALL always win when requesting, other ports in ascending index order, and the round-robin pointer SHALL be removed.
REQ-026 Without STORE_ARB_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-020.

Structure
REQ-027 store_port_req_t (address PLEN bits, data DATA_W, be DATA_W/8, size 2 bits) SHALL be defined in ariane_pkg.
REQ-028 Winner selection SHALL be a sub-module store_arb_rr (request vector + pointer in, one-hot grant + index out).

Verification
REQ-029 Reset then req_i=2'b11, dcache_gnt_i=1 constant -> gnt_o 01, 10, 01 on consecutive cycles; dcache_req_o high from cycle 1.
REQ-030 req_i=2'b01, payload addr 0x80001000, dcache_gnt_i=0 for 5 cycles -> single gnt_o pulse, dcache_payload_o stable 0x80001000 all 5 cycles, gnt_o=0 meanwhile.
REQ-031 HOLD with dcache_gnt_i=1 and req_i=2'b10 same cycle -> gnt_o=10 that cycle, winner_id_o=1 next cycle, no IDLE bubble.
REQ-032 rst_ni=0 asserted mid-HOLD -> next cycle dcache_req_o=0, busy_o=0; next grant goes to port 0.
REQ-033 With STORE_ARB_FIXED_PRIO_EN, req_i=2'b11 held, dcache_gnt_i=1 -> gnt_o=01 every cycle, port 1 starved.
REQ-034 dcache_gnt_i=1 pulsed in IDLE with req_i=0 -> no state change, all outputs remain zero.

Source files
------------

// File: rtl/ariane_pkg.sv
// -----------------------------------------------------------------------------
// ariane_pkg
// Shared types for the store-port arbiter slice.
//   store_port_req_t   : one store request (address, data, byte enables, size)
//   store_arb_state_e  : arbiter FSM state (IDLE = buffer empty, HOLD = store held)
//   wrap_idx()         : modulo helper used by the round-robin search
// -----------------------------------------------------------------------------
package ariane_pkg;

    localparam int PLEN         = 56;
    localparam int STORE_DATA_W = 64;

    typedef struct packed {
        logic [PLEN-1:0]             address;
        logic [STORE_DATA_W-1:0]     data;
        logic [STORE_DATA_W/8-1:0]   be;
        logic [1:0]                  size;
    } store_port_req_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } store_arb_state_e;

    // Wraps an index that has stepped at most one full lap past n-1.
    function automatic int wrap_idx(input int i, input int n);
        return (i >= n) ? (i - n) : i;
    endfunction

endpackage

// File: rtl/store_arb_rr.sv
// -----------------------------------------------------------------------------
// store_arb_rr
// Combinational winner selection: the first requesting index strictly after
// i_ptr, wrapping NR_PORTS-1 -> 0. Driving i_ptr with NR_PORTS-1 turns this
// into a fixed ascending-priority picker (port 0 first).
// Ports:
//   i_req   [NR_PORTS]  request vector
//   i_ptr   [IDX_W]     index of the previous winner
//   o_gnt   [NR_PORTS]  one-hot grant (zero when nothing requests)
//   o_idx   [IDX_W]     binary index of the granted requester
//   o_valid             any request present
// -----------------------------------------------------------------------------
module store_arb_rr
    import ariane_pkg::*;
#(
    parameter  int NR_PORTS = 2,
    localparam int IDX_W    = $clog2(NR_PORTS)
) (
    input  logic [NR_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]    i_ptr,
    output logic [NR_PORTS-1:0] o_gnt,
    output logic [IDX_W-1:0]    o_idx,
    output logic                o_valid
);

    always_comb begin
        int               v_cand;
        logic [IDX_W-1:0] v_idx;
        logic             v_found;

        o_gnt   = '0;
        o_idx   = '0;
        v_found = 1'b0;
        v_cand  = 0;
        v_idx   = '0;
        // Offsets 1..NR_PORTS: the previous winner is visited last.
        for (int k = 1; k <= NR_PORTS; k++) begin
            v_cand = wrap_idx(int'(i_ptr) + k, NR_PORTS);
            v_idx  = v_cand[IDX_W-1:0];
            if (!v_found && i_req[v_idx]) begin
                v_found      = 1'b1;
                o_gnt[v_idx] = 1'b1;
                o_idx        = v_idx;
            end
        end
        o_valid = v_found;
    end

endmodule

// File: rtl/store_port_arbiter.sv
// -----------------------------------------------------------------------------
// store_port_arbiter
// Shares the D$ write port between NR_PORTS store requesters through a
// one-entry holding buffer. A store is accepted (gnt_o pulse) when the buffer
// is empty or is being drained in the same cycle, so back-to-back stores flow
// at one per cycle.
// Build option: define STORE_ARB_FIXED_PRIO_EN for fixed priority (port 0
// highest, ascending order); otherwise round-robin with a last-winner pointer.
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   req_i, req_payload_i per-requester valid and store payload
//   gnt_o                one-hot acceptance pulse
//   dcache_req_o         held store valid
//   dcache_payload_o     held store payload
//   dcache_gnt_i         downstream accepted the held store
//   busy_o               buffer occupied (state == HOLD)
//   winner_id_o          requester index of the held store
// -----------------------------------------------------------------------------
module store_port_arbiter
    import ariane_pkg::*;
#(
    parameter  int NR_PORTS = 2,
    parameter  int DATA_W   = 64,
    localparam int IDX_W    = $clog2(NR_PORTS)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NR_PORTS-1:0]              req_i,
    input  store_port_req_t [NR_PORTS-1:0]   req_payload_i,
    output logic [NR_PORTS-1:0]              gnt_o,
    output logic                             dcache_req_o,
    output store_port_req_t                  dcache_payload_o,
    input  logic                             dcache_gnt_i,
    output logic                             busy_o,
    output logic [IDX_W-1:0]                 winner_id_o
);

    if (DATA_W != STORE_DATA_W) begin : g_bad_data_w
        $error("DATA_W must match ariane_pkg::STORE_DATA_W");
    end
    if (NR_PORTS < 2 || NR_PORTS > 4) begin : g_bad_nr_ports
        $error("NR_PORTS must be in 2..4");
    end

    store_arb_state_e      r_state;
    store_arb_state_e      w_state_nxt;
    store_port_req_t       r_payload;
    logic [IDX_W-1:0]      r_winner_id;
    logic [IDX_W-1:0]      w_ptr;
    logic [NR_PORTS-1:0]   w_rr_gnt;
    logic [IDX_W-1:0]      w_rr_idx;
    logic                  w_rr_valid;
    logic                  w_accept;
    logic                  w_take;

    store_arb_rr #(
        .NR_PORTS (NR_PORTS)
    ) u_rr (
        .i_req   (req_i),
        .i_ptr   (w_ptr),
        .o_gnt   (w_rr_gnt),
        .o_idx   (w_rr_idx),
        .o_valid (w_rr_valid)
    );

`ifdef STORE_ARB_FIXED_PRIO_EN
    // Constant "previous winner" of NR_PORTS-1 makes the search start at port 0.
    assign w_ptr = IDX_W'(NR_PORTS - 1);
`else
    logic [IDX_W-1:0] r_ptr;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ptr <= IDX_W'(NR_PORTS - 1);
        end else if (w_take) begin
            r_ptr <= w_rr_idx;
        end
    end

    assign w_ptr = r_ptr;
`endif

    // The buffer can take a new store when empty, or when it drains this cycle.
    // Reset suppresses acceptance so nothing is granted that would be discarded.
    assign w_accept = rst_ni && ((r_state == ST_IDLE) || dcache_gnt_i);
    assign w_take   = w_accept && w_rr_valid;
    assign gnt_o    = w_take ? w_rr_gnt : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_rr_valid) w_state_nxt = ST_HOLD;
            ST_HOLD: if (dcache_gnt_i && !w_rr_valid) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_payload   <= '0;
            r_winner_id <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_payload   <= req_payload_i[w_rr_idx];
                r_winner_id <= w_rr_idx;
            end
        end
    end

    assign dcache_req_o     = (r_state == ST_HOLD);
    assign busy_o           = (r_state == ST_HOLD);
    assign dcache_payload_o = r_payload;
    assign winner_id_o      = r_winner_id;

endmodule

// File: tb/tb_store_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_store_port_arbiter
// Directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a queue-free behavioural model of the arbiter
// (holding buffer + last-winner index). Define STORE_ARB_FIXED_PRIO_EN for
// the fixed-priority build.
// -----------------------------------------------------------------------------
module tb_store_port_arbiter;
    import ariane_pkg::*;

    localparam int N  = 2;
    localparam int IW = $clog2(N);

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [N-1:0]            req;
    store_port_req_t [N-1:0] pl;
    logic [N-1:0]            gnt;
    logic                    dreq;
    store_port_req_t         dpl;
    logic                    dgnt;
    logic                    busy;
    logic [IW-1:0]           wid;

    always #5 clk = ~clk;

    store_port_arbiter #(
        .NR_PORTS (N),
        .DATA_W   (64)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_i            (req),
        .req_payload_i    (pl),
        .gnt_o            (gnt),
        .dcache_req_o     (dreq),
        .dcache_payload_o (dpl),
        .dcache_gnt_i     (dgnt),
        .busy_o           (busy),
        .winner_id_o      (wid)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit              m_en = 1'b0;
    bit              m_hold = 1'b0;
    store_port_req_t m_pl = '0;
    int              m_id = 0;
    int              m_last = N - 1;

    always @(negedge clk) begin
        logic [N-1:0] e_gnt;
        int           w;
        int           c;
        if (m_en) begin
            e_gnt = '0;
            w     = -1;
            c     = 0;
            if (rst_n === 1'b1 && (!m_hold || dgnt === 1'b1)) begin
`ifdef STORE_ARB_FIXED_PRIO_EN
                for (int k = 0; k < N; k++)
                    if (w < 0 && req[k] === 1'b1) w = k;
`else
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (w < 0 && req[c] === 1'b1) w = c;
                end
`endif
                if (w >= 0) e_gnt[w] = 1'b1;
            end
            check("m_gnt",     gnt,  e_gnt);
            check("m_dreq",    dreq, m_hold);
            check("m_busy",    busy, m_hold);
            check("m_wid",     wid,  m_id);
            check("m_payload", dpl,  m_pl);
            // state after the coming rising edge
            if (rst_n !== 1'b1) begin
                m_hold = 1'b0;
                m_pl   = '0;
                m_id   = 0;
                m_last = N - 1;
            end else if (w >= 0) begin
                m_hold = 1'b1;
                m_pl   = pl[w];
                m_id   = w;
                m_last = w;
            end else if (m_hold && dgnt === 1'b1) begin
                m_hold = 1'b0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_payload(input int k);
        logic [159:0] tmp;
        tmp   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        pl[k] = tmp[$bits(store_port_req_t)-1:0];
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        dgnt  = 1'b0;
        pl    = '0;
        tick();
        m_en = 1'b1;

        // reset state
        @(negedge clk);
        check("rst_dreq", dreq, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_gnt",  gnt,  2'b00);
        check("rst_wid",  wid,  1'b0);

        // both requesting, downstream always ready
        tick();
        rst_n = 1'b1;
        req   = 2'b11;
        dgnt  = 1'b1;
        @(negedge clk);
        check("b2b_c0_gnt",  gnt,  2'b01);
        check("b2b_c0_dreq", dreq, 1'b0);
        tick();
        @(negedge clk);
`ifdef STORE_ARB_FIXED_PRIO_EN
        check("b2b_c1_gnt", gnt, 2'b01);
`else
        check("b2b_c1_gnt", gnt, 2'b10);
`endif
        check("b2b_c1_dreq", dreq, 1'b1);
        tick();
        @(negedge clk);
        check("b2b_c2_gnt", gnt, 2'b01);

        // drain the held store
        tick();
        req = 2'b00;
        @(negedge clk);
        check("drain_gnt", gnt, 2'b00);

        // single requester, downstream stalled for 5 cycles
        tick();
        dgnt           = 1'b0;
        req            = 2'b01;
        pl[0].address  = 56'h80001000;
        @(negedge clk);
        check("stall_gnt0", gnt,  2'b01);
        check("stall_idle", dreq, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            check("stall_gnt",  gnt,         2'b00);
            check("stall_dreq", dreq,        1'b1);
            check("stall_addr", dpl.address, 56'h80001000);
        end

        // drain and accept a new store in the same cycle
        tick();
        dgnt          = 1'b1;
        req           = 2'b10;
        pl[1].address = 56'h80002000;
        @(negedge clk);
        check("b2b_new_gnt", gnt, 2'b10);
        check("b2b_old_wid", wid, 1'b0);
        tick();
        dgnt = 1'b0;
        req  = 2'b00;
        @(negedge clk);
        check("b2b_new_wid",  wid,         1'b1);
        check("b2b_new_busy", busy,        1'b1);
        check("b2b_new_addr", dpl.address, 56'h80002000);

        // reset while holding; requests during reset must not be granted
        tick();
        rst_n = 1'b0;
        req   = 2'b11;
        @(negedge clk);
        check("rst_hold_gnt", gnt, 2'b00);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_hold_dreq", dreq, 1'b0);
        check("rst_hold_busy", busy, 1'b0);
        check("rst_hold_gnt0", gnt,  2'b01);
        tick();
        req  = 2'b00;
        dgnt = 1'b1;
        @(negedge clk);
        check("rst_hold_wid", wid, 1'b0);

        // downstream grant in IDLE with nothing requesting
        tick();
        rst_n = 1'b0;
        dgnt  = 1'b0;
        tick();
        rst_n = 1'b1;
        dgnt  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_gnt",  gnt,  2'b00);
            check("idle_dreq", dreq, 1'b0);
            check("idle_busy", busy, 1'b0);
            check("idle_pl",   dpl,  '0);
            tick();
        end

        // randomized traffic; requests mostly sticky
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 9) < 4) begin
                    req[k] = ($urandom_range(0, 9) < 6);
                    rand_payload(k);
                end
            end
            dgnt  = ($urandom_range(0, 9) < 6);
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end

        rst_n = 1'b1;
        req   = '0;
        dgnt  = 1'b1;
        tick();
        tick();
        m_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
